// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 decryptor: forward/inverse
// S-box tables, round constants, GF(2^8) helpers and the FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } aes_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Indexed directly by the round number 1..10; unused slots read as zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// 8-bit combinational AES inverse S-box, one byte lane of InvSubBytes.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward to rk10 over ten
// cycles, then runs ten inverse rounds while walking the key schedule back.
// Optional feature macro: AES_DEC_KEY_CACHE_EN keeps the last key and its rk10
// so a repeated key skips the forward expansion.
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  aes_state_t   st;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [3:0]   rnd_q;

  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [31:0]  inv_w3;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  rcon_w;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [127:0] key_fwd;
  logic [127:0] key_inv;
  logic [127:0] srows;
  logic [127:0] sbytes;
  logic [127:0] ark;
  logic [127:0] imc;
  logic [127:0] round_out;
  logic         cache_hit;
  logic [127:0] hit_rk10;

  assign in_ready = (st == IDLE);
  assign busy     = (st != IDLE);

  // The same four key-path S-boxes serve the forward step (on w3) and the
  // inverse step (on the recovered w3' = w3 ^ w2).
  assign {kw0, kw1, kw2, kw3} = key_q;
  assign inv_w3  = kw3 ^ kw2;
  assign sub_in  = (st == ROUND) ? inv_w3 : kw3;
  assign sub_out = sub_word({sub_in[23:0], sub_in[31:24]});
  assign rcon_w  = {RCON[rnd_q], 24'h000000};

  assign fw0     = kw0 ^ sub_out ^ rcon_w;
  assign fw1     = kw1 ^ fw0;
  assign fw2     = kw2 ^ fw1;
  assign fw3     = kw3 ^ fw2;
  assign key_fwd = {fw0, fw1, fw2, fw3};
  assign key_inv = {kw0 ^ sub_out ^ rcon_w, kw1 ^ kw0, kw2 ^ kw1, inv_w3};

  // InvShiftRows: row r rotates right by r columns (byte 4c+r is row r, col c).
  always_comb begin
    srows = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        srows[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_isbox
    aes_inv_sbox u_isbox (
      .in_byte  (srows[127-8*g -: 8]),
      .out_byte (sbytes[127-8*g -: 8])
    );
  end

  assign ark = sbytes ^ key_inv;

  // InvMixColumns on each 32-bit column of the post-AddRoundKey state.
  always_comb begin
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
    end
  end

  assign round_out = (rnd_q == 4'd1) ? ark : imc;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] cache_key;
  logic [127:0] cache_rk10;
  logic         cache_vld;

  assign cache_hit = cache_vld && (in_key == cache_key);
  assign hit_rk10  = cache_rk10;

  // Cache tag is captured on a missed accept and validated once rk10 exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_key  <= '0;
      cache_rk10 <= '0;
      cache_vld  <= 1'b0;
    end else if (st == IDLE && in_valid && !cache_hit) begin
      cache_key <= in_key;
      cache_vld <= 1'b0;
    end else if (st == KEYEXP && rnd_q == 4'd10) begin
      cache_rk10 <= key_fwd;
      cache_vld  <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_rk10  = '0;
`endif

  // Control FSM plus the state, round-key and round-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      rnd_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            if (cache_hit) begin
              state_q <= in_data ^ hit_rk10;
              key_q   <= hit_rk10;
              rnd_q   <= 4'd10;
              st      <= ROUND;
            end else begin
              state_q <= in_data;
              key_q   <= in_key;
              rnd_q   <= 4'd1;
              st      <= KEYEXP;
            end
          end
        end
        KEYEXP: begin
          key_q <= key_fwd;
          if (rnd_q == 4'd10) begin
            state_q <= state_q ^ key_fwd;
            st      <= ROUND;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        ROUND: begin
          key_q   <= key_inv;
          state_q <= round_out;
          rnd_q   <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            st        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: known-answer vector table driven
// through a scoreboard, plus hand sequences for reset, rk10, hold and abort.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           hold;
    bit           noise;
  } vec_t;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int unsigned  acc;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

`ifdef AES_DEC_KEY_CACHE_EN
  bit           mdl_vld = 1'b0;
  logic [127:0] mdl_key = '0;
`endif

  aes_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case a sequence wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkEq(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for the accept edge and log the expectation.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] ct,
                               input logic [127:0] pt, input bit noise);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_data  = ct;
    in_key   = key;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    tick();
    e.pt  = pt;
    e.acc = cyc;
`ifdef AES_DEC_KEY_CACHE_EN
    e.lat   = (mdl_vld && key == mdl_key) ? 10 : 20;
    mdl_key = key;
    mdl_vld = 1'b1;
`else
    e.lat = 20;
`endif
    sb.push_back(e);
    checkEq("busy_after_accept", 128'(busy), 128'(1));
    in_valid = noise;
    in_data  = rand128();
    in_key   = rand128();
  endtask

  // Wait for the plaintext, compare against the scoreboard, hold, then retire.
  task automatic checkOutput(input int hold, input bit noise);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
      if (noise && !out_valid) begin
        checkEq("busy_in_ready", 128'(in_ready), 128'(0));
        in_data = rand128();
        in_key  = rand128();
      end
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("[TB] FAIL output_timeout: out_valid stayed %b, expected 1", out_valid);
      if (sb.size() > 0) void'(sb.pop_front());
      in_valid = 1'b0;
      return;
    end
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL unexpected_output: got %h, expected no output", out_data);
      return;
    end
    e = sb.pop_front();
    checkEq("plaintext", out_data, e.pt);
    checkEq("latency", 128'(cyc - e.acc), 128'(e.lat));
    for (int h = 0; h < hold; h++) begin
      tick();
      checkEq("hold_data", out_data, e.pt);
      checkEq("hold_valid", 128'(out_valid), 128'(1));
      checkEq("hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkEq("retire_valid", 128'(out_valid), 128'(0));
    checkEq("retire_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    bit seen;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 0, 1'b0};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 7, 1'b0};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a, 2, 1'b1};
    vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf,
                128'hae2d8a571e03ac9c9eb76fac45af8e51, 0, 1'b0};
    vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h43b1cd7f598ece23881b00e3ed030688,
                128'h30c81c46a35ce411e5fbc1191a0a52ef, 1, 1'b1};
    vecs[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h7b0c785e27e8ad3f8223207104725dd4,
                128'hf69f2445df4f9b17ad2b417be66c3710, 0, 1'b0};
    vecs[6] = '{128'h00000000000000000000000000000000, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                128'h00000000000000000000000000000000, 3, 1'b0};
    vecs[7] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 0, 1'b1};

    // Reset state, with a request pending that must not be taken.
    in_valid = 1'b1;
    in_data  = vecs[0].ct;
    in_key   = vecs[0].key;
    repeat (3) tick();
    checkEq("reset_out_valid", 128'(out_valid), 128'(0));
    checkEq("reset_out_data", out_data, 128'(0));
    checkEq("reset_busy", 128'(busy), 128'(0));
    checkEq("reset_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    checkEq("post_reset_idle", 128'(busy), 128'(0));

    // Forward key schedule must reach rk10 ten edges after accept.
    applyStimulus(vecs[1].key, vecs[1].ct, vecs[1].pt, 1'b0);
    repeat (10) tick();
    checkEq("rk10", dut.key_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    checkOutput(0, 1'b0);

    // Known-answer table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].noise);
      checkOutput(vecs[i].hold, vecs[i].noise);
    end

    // Abort mid-round with reset; nothing may come out afterwards.
    applyStimulus(vecs[0].key, vecs[0].ct, vecs[0].pt, 1'b0);
    repeat (11) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("abort_out_valid", 128'(out_valid), 128'(0));
    checkEq("abort_busy", 128'(busy), 128'(0));
    checkEq("abort_in_ready", 128'(in_ready), 128'(1));
    checkEq("abort_out_data", out_data, 128'(0));
    sb.delete();
`ifdef AES_DEC_KEY_CACHE_EN
    mdl_vld = 1'b0;
`endif
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      seen |= out_valid | busy;
    end
    checkEq("abort_no_output", 128'(seen), 128'(0));
    applyStimulus(vecs[1].key, vecs[1].ct, vecs[1].pt, 1'b0);
    checkOutput(0, 1'b0);

    checkEq("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
